// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the frame commit buffer.
package frame_buf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam int STORE_W   = 9;  // {last, byte}
    localparam int FCS_BYTES = 4;

endpackage

// File: rtl/frame_commit_buffer_dibit_packer.sv
// MSB-first dibit-to-byte packer; the first dibit of a byte lands in [7:6].
module dibit_packer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_vld,
    input  logic [1:0] i_dibit,
    output logic       o_byte_vld,
    output logic [7:0] o_byte,
    output logic       o_aligned
);

    logic [1:0] r_cnt;
    logic [5:0] r_sr;
    logic [1:0] w_cnt_base;

    // A clear and the first dibit of a frame can arrive in the same cycle.
    assign w_cnt_base = i_clr ? 2'd0 : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= 2'd0;
        else if (i_vld)
            r_cnt <= w_cnt_base + 2'd1;
        else if (i_clr)
            r_cnt <= 2'd0;
    end

    always_ff @(posedge clk) begin
        if (i_vld)
            r_sr <= {r_sr[3:0], i_dibit};
    end

    assign o_byte     = {r_sr, i_dibit};
    assign o_byte_vld = i_vld & (w_cnt_base == 2'd3);
    assign o_aligned  = (r_cnt == 2'd0);

endmodule

// File: rtl/frame_commit_buffer.sv
// Stages received frames in a ring buffer and releases only committed frames.
// Build option FRAME_STRIP_FCS_EN: hold back the 4 FCS bytes and drop them on commit.
module frame_commit_buffer
    import frame_buf_pkg::*;
#(
    parameter int DEPTH = 2048,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             axiiv,
    input  logic [1:0]       axiid,
    input  logic             done,
    input  logic             kill,
    output logic             axiov,
    output logic [7:0]       axiod,
    output logic             axiol,
    input  logic             axior,
    output logic [CNT_W-1:0] good_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
`ifdef FRAME_STRIP_FCS_EN
    localparam int HOLD_N = FCS_BYTES + 1;
`else
    localparam int HOLD_N = 1;
`endif
    localparam int HC_W = $clog2(HOLD_N + 1);

    state_t             r_state, w_state_nxt;
    logic [PW-1:0]      r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic [STORE_W-1:0] r_mem [DEPTH];
    logic [7:0]         r_hold [HOLD_N];
    logic [HC_W-1:0]    r_hold_cnt;
    logic               r_done_q;

    logic               w_byte_vld, w_aligned;
    logic [7:0]         w_byte;
    logic               w_full, w_empty, w_hold_full, w_done_rise;
    logic               w_shift, w_shift_wr, w_commit, w_drop, w_we;
    logic [STORE_W-1:0] w_wdata;

    dibit_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (r_state == IDLE),
        .i_vld      (axiiv && (r_state != DISCARD)),
        .i_dibit    (axiid),
        .o_byte_vld (w_byte_vld),
        .o_byte     (w_byte),
        .o_aligned  (w_aligned)
    );

    assign w_full      = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
    assign w_empty     = (r_rd_ptr == r_commit_ptr);
    assign w_hold_full = (r_hold_cnt == HC_W'(HOLD_N));
    assign w_done_rise = done & ~r_done_q;

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_shift_wr  = 1'b0;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (axiiv)
                    w_state_nxt = RECV;
            end
            RECV: begin
                if (axiiv) begin
                    if (w_byte_vld) begin
                        if (w_hold_full && w_full) begin
                            w_state_nxt = DISCARD;
                        end else begin
                            w_shift    = 1'b1;
                            w_shift_wr = w_hold_full;
                        end
                    end
                end else begin
                    // Verdict cycle: hold_full also enforces the minimum frame length.
                    if (w_done_rise && !kill && w_aligned && w_hold_full && !w_full)
                        w_commit = 1'b1;
                    else
                        w_drop = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DISCARD: begin
                if (!axiiv) begin
                    w_drop      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_we    = w_shift_wr | w_commit;
    assign w_wdata = {w_commit, r_hold[HOLD_N-1]};

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (w_shift) begin
            r_hold[0] <= w_byte;
            for (int i = 1; i < HOLD_N; i++)
                r_hold[i] <= r_hold[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_done_q     <= 1'b0;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_hold_cnt   <= '0;
            good_count   <= '0;
            drop_count   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_done_q <= done;
            if (w_shift && !w_hold_full)
                r_hold_cnt <= r_hold_cnt + HC_W'(1);
            if (w_commit || w_drop)
                r_hold_cnt <= '0;
            if (w_shift_wr)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_commit) begin
                r_wr_ptr     <= r_wr_ptr + PW'(1);
                r_commit_ptr <= r_wr_ptr + PW'(1);
                good_count   <= good_count + CNT_W'(1);
            end
            // Rollback: uncommitted bytes all sit beyond commit_ptr.
            if (w_drop) begin
                r_wr_ptr   <= r_commit_ptr;
                drop_count <= drop_count + CNT_W'(1);
            end
            if (!w_empty && axior)
                r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    assign axiov          = ~w_empty;
    assign {axiol, axiod} = w_empty ? {1'b0, 8'h00} : r_mem[r_rd_ptr[AW-1:0]];

endmodule
